// File: rtl/m_ext_seq_pkg.sv
// Shared encodings for the RV32IM M-extension sequencer: decode constants,
// funct3 operation map and the FSM state encoding.
package m_ext_seq_pkg;

  localparam logic [6:0] M_OPCODE = 7'b0110011;
  localparam logic [6:0] M_FUNCT7 = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DIV  = 2'b10,
    ST_DONE = 2'b11
  } state_e;

endpackage

// File: rtl/m_ext_div_core.sv
// Iterative restoring radix-2 divider on unsigned magnitudes, one quotient
// bit per cycle, MSB first. quotient/remainder show the result of the step
// being taken this cycle, so they are final in the cycle done is high.
module m_ext_div_core #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  localparam int CW = $clog2(XLEN) + 1;

  logic            busy_q, busy_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] dvs_q, dvs_d;

  logic [XLEN:0]   shifted;
  logic [XLEN:0]   trial;
  logic            step_bit;
  logic [XLEN-1:0] step_rem;
  logic [XLEN-1:0] step_quo;

  always_comb begin
    // trial[XLEN] is the borrow: the partial remainder is always below
    // twice the divisor, so the difference fits in XLEN+1 bits.
    shifted  = {rem_q, quo_q[XLEN-1]};
    trial    = shifted - {1'b0, dvs_q};
    step_bit = ~trial[XLEN];
    step_rem = step_bit ? trial[XLEN-1:0] : shifted[XLEN-1:0];
    step_quo = {quo_q[XLEN-2:0], step_bit};

    done      = busy_q && (cnt_q == CW'(XLEN - 1));
    quotient  = step_quo;
    remainder = step_rem;

    busy_d = busy_q;
    cnt_d  = cnt_q;
    quo_d  = quo_q;
    rem_d  = rem_q;
    dvs_d  = dvs_q;

    if (start) begin
      busy_d = 1'b1;
      cnt_d  = '0;
      quo_d  = dividend;
      rem_d  = '0;
      dvs_d  = divisor;
    end else if (abort) begin
      busy_d = 1'b0;
    end else if (busy_q) begin
      quo_d = step_quo;
      rem_d = step_rem;
      cnt_d = cnt_q + 1'b1;
      if (done) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
    end
  end

endmodule

// File: rtl/m_ext_seq.sv
// M-extension sequencer: decodes MUL/DIV/REM variants, stalls the pipeline
// while the operation runs and returns a registered result with a done strobe.
module m_ext_seq
  import m_ext_seq_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int MUL_LAT   = 2,
  parameter int DIV_EARLY = 1
) (
  input  logic            ip_clk,
  input  logic            ip_rst,
  input  logic            ip_valid,
  input  logic [6:0]      ip_opcode,
  input  logic [6:0]      ip_funct_7,
  input  logic [2:0]      ip_funct_3,
  input  logic [XLEN-1:0] ip_rs1_data,
  input  logic [XLEN-1:0] ip_rs2_data,
  input  logic            ip_flush,
  output logic            op_stall,
  output logic            op_busy,
  output logic            op_done,
  output logic [XLEN-1:0] op_result
);

  localparam int NSTG = (MUL_LAT > 1) ? MUL_LAT - 1 : 1;
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [2:0]        f3_q, f3_d;
  logic              q_neg_q, q_neg_d;
  logic              r_neg_q, r_neg_d;
  logic              dz_q, dz_d;
  logic              ovf_q, ovf_d;
  logic [XLEN-1:0]   rs1_q, rs1_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [2*XLEN-1:0] prod_q [NSTG];
  logic [2*XLEN-1:0] prod_d [NSTG];

  logic              is_m, accept, acc_div, acc_sdiv;
  logic              a_neg, b_neg, acc_dz, acc_ovf, acc_early;
  logic              div_start, div_done;
  logic [XLEN-1:0]   a_mag, b_mag, div_quo, div_rem;
  logic [XLEN-1:0]   q_fix, r_fix, div_res, early_res;
  logic [2*XLEN-1:0] mul_a_ext, mul_b_ext, mul_prod;

  function automatic logic [XLEN-1:0] mul_pick(input logic [2:0] f3,
                                                input logic [2*XLEN-1:0] p);
    return (f3 == F3_MUL) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
  endfunction

  // Decode and operand preparation for the accept cycle.
  always_comb begin
    is_m     = ip_valid && (ip_opcode == M_OPCODE) && (ip_funct_7 == M_FUNCT7);
    accept   = is_m && !ip_flush && (state_q == ST_IDLE);
    acc_div  = ip_funct_3[2];
    acc_sdiv = (ip_funct_3 == F3_DIV) || (ip_funct_3 == F3_REM);
    a_neg    = acc_sdiv && ip_rs1_data[XLEN-1];
    b_neg    = acc_sdiv && ip_rs2_data[XLEN-1];
    a_mag    = a_neg ? -ip_rs1_data : ip_rs1_data;
    b_mag    = b_neg ? -ip_rs2_data : ip_rs2_data;
    acc_dz   = (ip_rs2_data == '0);
    acc_ovf  = acc_sdiv && (ip_rs1_data == MOST_NEG) && (ip_rs2_data == '1);
    acc_early = (DIV_EARLY != 0) && (acc_dz || acc_ovf);
    div_start = accept && acc_div && !acc_early;

    mul_a_ext = {{XLEN{((ip_funct_3 == F3_MULH) || (ip_funct_3 == F3_MULHSU))
                       && ip_rs1_data[XLEN-1]}}, ip_rs1_data};
    mul_b_ext = {{XLEN{(ip_funct_3 == F3_MULH) && ip_rs2_data[XLEN-1]}}, ip_rs2_data};
    mul_prod  = mul_a_ext * mul_b_ext;

    if (acc_dz) early_res = ip_funct_3[1] ? ip_rs1_data : '1;
    else        early_res = ip_funct_3[1] ? '0 : ip_rs1_data;
  end

  m_ext_div_core #(.XLEN(XLEN)) u_div (
    .clk       (ip_clk),
    .rst       (ip_rst),
    .start     (div_start),
    .abort     (ip_flush),
    .dividend  (a_mag),
    .divisor   (b_mag),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  // Sign fix-up; special cases override so DIV_EARLY=0 still returns
  // the architected divide-by-zero and overflow values.
  always_comb begin
    q_fix = q_neg_q ? -div_quo : div_quo;
    r_fix = r_neg_q ? -div_rem : div_rem;
    if (dz_q) begin
      q_fix = '1;
      r_fix = rs1_q;
    end else if (ovf_q) begin
      q_fix = rs1_q;
      r_fix = '0;
    end
    div_res = f3_q[1] ? r_fix : q_fix;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    f3_d     = f3_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    dz_d     = dz_q;
    ovf_d    = ovf_q;
    rs1_d    = rs1_q;
    result_d = result_q;

    prod_d[0] = accept ? mul_prod : prod_q[0];
    for (int i = 1; i < NSTG; i++) prod_d[i] = prod_q[i-1];

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          f3_d    = ip_funct_3;
          q_neg_d = a_neg ^ b_neg;
          r_neg_d = a_neg;
          dz_d    = acc_dz;
          ovf_d   = acc_ovf;
          rs1_d   = ip_rs1_data;
          cnt_d   = '0;
          if (!acc_div) begin
            if (MUL_LAT == 1) begin
              state_d  = ST_DONE;
              result_d = mul_pick(ip_funct_3, mul_prod);
            end else begin
              state_d = ST_MUL;
            end
          end else if (acc_early) begin
            state_d  = ST_DONE;
            result_d = early_res;
          end else begin
            state_d = ST_DIV;
          end
        end
      end
      ST_MUL: begin
        if (ip_flush) begin
          state_d = ST_IDLE;
        end else if (cnt_q == 3'(MUL_LAT - 2)) begin
          state_d  = ST_DONE;
          result_d = mul_pick(f3_q, prod_q[NSTG-1]);
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      ST_DIV: begin
        if (ip_flush) begin
          state_d = ST_IDLE;
        end else if (div_done) begin
          state_d  = ST_DONE;
          result_d = div_res;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ip_clk or posedge ip_rst) begin
    if (ip_rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      f3_q     <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      dz_q     <= 1'b0;
      ovf_q    <= 1'b0;
      rs1_q    <= '0;
      result_q <= '0;
      for (int i = 0; i < NSTG; i++) prod_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      f3_q     <= f3_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      dz_q     <= dz_d;
      ovf_q    <= ovf_d;
      rs1_q    <= rs1_d;
      result_q <= result_d;
      for (int i = 0; i < NSTG; i++) prod_q[i] <= prod_d[i];
    end
  end

  // Stall is combinational in IDLE so the accept cycle already holds upstream.
  assign op_stall  = (is_m && (state_q == ST_IDLE)) || (state_q == ST_MUL) || (state_q == ST_DIV);
  assign op_busy   = (state_q != ST_IDLE);
  assign op_done   = (state_q == ST_DONE);
  assign op_result = result_q;

endmodule

// File: tb/tb_m_ext_seq.sv
// Bench for m_ext_seq: directed and random M-extension operations checked
// against an arithmetic reference model, plus flush, reset and decode cases.
module tb_m_ext_seq;

  localparam int XLEN      = 32;
  localparam int MUL_LAT   = 2;
  localparam int DIV_EARLY = 1;
  localparam logic [6:0]  OPC_OP = 7'b0110011;
  localparam logic [6:0]  F7_M   = 7'b0000001;
  localparam logic [31:0] MIN32  = 32'h8000_0000;

  logic            ip_clk = 1'b0;
  logic            ip_rst = 1'b0;
  logic            ip_valid = 1'b0;
  logic [6:0]      ip_opcode = '0;
  logic [6:0]      ip_funct_7 = '0;
  logic [2:0]      ip_funct_3 = '0;
  logic [XLEN-1:0] ip_rs1_data = '0;
  logic [XLEN-1:0] ip_rs2_data = '0;
  logic            ip_flush = 1'b0;
  logic            op_stall, op_busy, op_done;
  logic [XLEN-1:0] op_result;

  int n_checks = 0;
  int n_fail   = 0;
  logic [XLEN-1:0] exp_q[$];
  int              lat_q[$];
  logic [XLEN-1:0] last_result = '0;

  always #5 ip_clk = ~ip_clk;

  m_ext_seq #(.XLEN(XLEN), .MUL_LAT(MUL_LAT), .DIV_EARLY(DIV_EARLY)) dut (
    .ip_clk      (ip_clk),
    .ip_rst      (ip_rst),
    .ip_valid    (ip_valid),
    .ip_opcode   (ip_opcode),
    .ip_funct_7  (ip_funct_7),
    .ip_funct_3  (ip_funct_3),
    .ip_rs1_data (ip_rs1_data),
    .ip_rs2_data (ip_rs2_data),
    .ip_flush    (ip_flush),
    .op_stall    (op_stall),
    .op_busy     (op_busy),
    .op_done     (op_done),
    .op_result   (op_result)
  );

  function automatic logic [31:0] ref_result(input logic [2:0] f3,
                                             input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    longint unsigned ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (f3)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == MIN32 && b == 32'hFFFF_FFFF) return a;
        p = sa / sb; return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == MIN32 && b == 32'hFFFF_FFFF) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] f3,
                                     input logic [31:0] a, input logic [31:0] b);
    bit is_signed;
    if (!f3[2]) return MUL_LAT;
    is_signed = (f3 == 3'd4) || (f3 == 3'd6);
    if (DIV_EARLY != 0 && (b == 0 || (is_signed && a == MIN32 && b == 32'hFFFF_FFFF)))
      return 1;
    return XLEN + 1;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return MIN32;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Drives one M instruction now and returns in its DONE cycle.
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] exp_r;
    int exp_l, n;
    exp_q.push_back(ref_result(f3, a, b));
    lat_q.push_back(ref_latency(f3, a, b));
    ip_valid = 1'b1; ip_opcode = OPC_OP; ip_funct_7 = F7_M;
    ip_funct_3 = f3; ip_rs1_data = a; ip_rs2_data = b;
    #1;
    n_checks++;
    if (op_stall !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_accept f3=%0d: got %b want 1", f3, op_stall);
    end
    @(posedge ip_clk); n = 1; #1;
    ip_valid = 1'b0;
    ip_funct_3 = 3'($urandom_range(0, 7));
    ip_rs1_data = $urandom; ip_rs2_data = $urandom;
    while (op_done !== 1'b1 && n < 80) begin
      @(posedge ip_clk); n++; #1;
    end
    exp_r = exp_q.pop_front();
    exp_l = lat_q.pop_front();
    n_checks++;
    if (op_done !== 1'b1) begin
      n_fail++;
      $display("FAIL done_timeout f3=%0d a=%h b=%h: no op_done within %0d cycles", f3, a, b, n);
    end else begin
      if (n != exp_l) begin
        n_fail++;
        $display("FAIL latency f3=%0d a=%h b=%h: got %0d want %0d", f3, a, b, n, exp_l);
      end
      n_checks++;
      if (op_result !== exp_r) begin
        n_fail++;
        $display("FAIL result f3=%0d a=%h b=%h: got %h want %h", f3, a, b, op_result, exp_r);
      end
      n_checks++;
      if (op_stall !== 1'b0 || op_busy !== 1'b1) begin
        n_fail++;
        $display("FAIL done_flags f3=%0d: stall=%b busy=%b want stall=0 busy=1", f3, op_stall, op_busy);
      end
    end
    last_result = exp_r;
  endtask

  task automatic idle_cycle();
    @(posedge ip_clk); #1;
    n_checks++;
    if (op_done !== 1'b0 || op_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL done_pulse: done=%b busy=%b want 0 0", op_done, op_busy);
    end
  endtask

  task automatic watch_no_done(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge ip_clk); #1;
      if (op_done === 1'b1 || op_busy === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (seen) begin
      n_fail++;
      $display("FAIL %s: op_done/op_busy seen after abort, want none", tag);
    end
  endtask

  task automatic test_reset();
    #1 ip_rst = 1'b1;
    repeat (2) @(posedge ip_clk);
    #1;
    n_checks++;
    if (op_result !== '0 || op_done !== 1'b0 || op_busy !== 1'b0 || op_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: result=%h done=%b busy=%b stall=%b want all 0",
               op_result, op_done, op_busy, op_stall);
    end
    ip_rst = 1'b0;
    @(posedge ip_clk); #1;
  endtask

  task automatic test_directed();
    issue(3'd0, 32'd7, 32'hFFFF_FFFD);          idle_cycle();
    issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);  idle_cycle();
    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);  idle_cycle();
    issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);  idle_cycle();
    issue(3'd4, 32'hFFFF_FFEC, 32'd3);          idle_cycle();
    issue(3'd6, 32'hFFFF_FFEC, 32'd3);          idle_cycle();
    issue(3'd5, 32'd100, 32'd7);                idle_cycle();
    issue(3'd7, 32'd100, 32'd7);                idle_cycle();
    issue(3'd5, 32'd5, 32'd0);                  idle_cycle();
    issue(3'd6, MIN32, 32'hFFFF_FFFF);          idle_cycle();
    issue(3'd4, MIN32, 32'hFFFF_FFFF);          idle_cycle();
    issue(3'd6, 32'hFFFF_FFF9, 32'd0);          idle_cycle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      issue(3'($urandom_range(0, 7)), pick_operand(), pick_operand());
      idle_cycle();
    end
  endtask

  task automatic test_back_to_back();
    issue(3'd0, $urandom, $urandom);
    // Next instruction already present during DONE must wait for IDLE.
    ip_valid = 1'b1; ip_opcode = OPC_OP; ip_funct_7 = F7_M;
    ip_funct_3 = 3'd7; ip_rs1_data = 32'd1000; ip_rs2_data = 32'd33;
    #1;
    n_checks++;
    if (op_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_done_stall: got %b want 0", op_stall);
    end
    @(posedge ip_clk); #1;
    n_checks++;
    if (op_busy !== 1'b0 || op_done !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_no_accept_in_done: busy=%b done=%b want 0 0", op_busy, op_done);
    end
    issue(3'd7, 32'd1000, 32'd33);
    idle_cycle();
  endtask

  task automatic test_flush();
    int k;
    // Flush in IDLE blocks accept.
    ip_valid = 1'b1; ip_opcode = OPC_OP; ip_funct_7 = F7_M;
    ip_funct_3 = 3'd0; ip_rs1_data = 32'd3; ip_rs2_data = 32'd4; ip_flush = 1'b1;
    @(posedge ip_clk); #1;
    ip_valid = 1'b0; ip_flush = 1'b0;
    n_checks++;
    if (op_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_idle_blocks: busy=%b want 0", op_busy);
    end
    ip_valid = 1'b1; ip_funct_3 = 3'd4; ip_rs1_data = 32'd12345; ip_rs2_data = 32'd7;
    @(posedge ip_clk); k = 1; #1;
    ip_valid = 1'b0;
    while (k < 10) begin @(posedge ip_clk); k++; #1; end
    ip_flush = 1'b1;
    @(posedge ip_clk); #1;
    ip_flush = 1'b0;
    n_checks++;
    if (op_busy !== 1'b0 || op_stall !== 1'b0 || op_done !== 1'b0 || op_result !== last_result) begin
      n_fail++;
      $display("FAIL flush_abort: busy=%b stall=%b done=%b result=%h want 0 0 0 %h",
               op_busy, op_stall, op_done, op_result, last_result);
    end
    watch_no_done("flush_no_done");
    issue(3'd0, $urandom, $urandom);
    idle_cycle();
  endtask

  task automatic test_reset_mid();
    int k;
    ip_valid = 1'b1; ip_opcode = OPC_OP; ip_funct_7 = F7_M;
    ip_funct_3 = 3'd4; ip_rs1_data = 32'hDEAD_BEEF; ip_rs2_data = 32'd9;
    @(posedge ip_clk); k = 1; #1;
    ip_valid = 1'b0;
    while (k < 5) begin @(posedge ip_clk); k++; #1; end
    #2 ip_rst = 1'b1;
    #1;
    n_checks++;
    if (op_busy !== 1'b0 || op_done !== 1'b0 || op_stall !== 1'b0 || op_result !== '0) begin
      n_fail++;
      $display("FAIL reset_async: busy=%b done=%b stall=%b result=%h want all 0",
               op_busy, op_done, op_stall, op_result);
    end
    @(posedge ip_clk); #2;
    ip_rst = 1'b0;
    last_result = '0;
    watch_no_done("reset_no_done");
  endtask

  task automatic test_non_m();
    bit bad;
    bad = 1'b0;
    ip_valid = 1'b1; ip_opcode = OPC_OP; ip_funct_7 = 7'b0000000;
    for (int i = 0; i < 6; i++) begin
      ip_funct_3 = 3'($urandom_range(0, 7));
      ip_rs1_data = $urandom; ip_rs2_data = $urandom;
      if (i >= 3) begin ip_opcode = 7'b0010011; ip_funct_7 = F7_M; end
      #1;
      if (op_stall !== 1'b0) bad = 1'b1;
      @(posedge ip_clk); #1;
      if (op_busy !== 1'b0 || op_stall !== 1'b0) bad = 1'b1;
    end
    ip_valid = 1'b0;
    n_checks++;
    if (bad) begin
      n_fail++;
      $display("FAIL non_m_ignored: stall/busy asserted for non-M instruction, want 0");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_non_m();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/m_ext_seq.md
Name: m_ext_seq

Overview:
- Multi-cycle sequencer and datapath for RV32IM M-extension instructions (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
- Sits beside the control unit in the execute stage.
- Decodes the same opcode/funct_3/funct_7 fields as the control unit and stalls the pipeline while an operation runs.
- Returns a registered XLEN-bit result with a one-cycle done strobe, which drives the M-extension write-back mux selected by the control unit.

Parameters:
- XLEN, 32, operand/result width; legal values 32 or 64 (64 reserved for RV64 reuse).
- MUL_LAT, 2, cycles from accept to op_done for multiply ops; legal range 1..4.
- DIV_EARLY, 1, 1 = divide-by-zero and signed-overflow cases bypass the iteration and finish in 1 cycle; 0 = always iterate.

Ports:
- ip_clk  input  1  system clock, rising edge
- ip_rst  input  1  asynchronous, active-high reset
- ip_valid  input  1  instruction in execute is valid
- ip_opcode  input  7  instruction opcode
- ip_funct_7  input  7  instruction funct7
- ip_funct_3  input  3  instruction funct3; selects the operation
- ip_rs1_data  input  XLEN  operand a (dividend / multiplicand)
- ip_rs2_data  input  XLEN  operand b (divisor / multiplier)
- ip_flush  input  1  pipeline flush; aborts the in-flight operation
- op_stall  output  1  hold upstream pipeline registers
- op_busy  output  1  FSM not IDLE
- op_done  output  1  one-cycle strobe; op_result valid
- op_result  output  XLEN  registered result

Behaviour:
- Reset state (asynchronous, active-high): FSM=IDLE, op_busy=0, op_done=0, op_result=0, all internal registers 0. Reset mid-operation abandons the operation; no op_done follows.
- is_m = ip_valid & (ip_opcode==7'b0110011) & (ip_funct_7==7'b0000001).
- Funct3 map: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- Accept: in IDLE with is_m=1 and ip_flush=0. Operands, funct3 and sign flags are latched on that edge.
- op_stall = (is_m & state==IDLE) | (state!=IDLE & state!=DONE). Stall is combinational from inputs in IDLE, so the accept cycle already stalls. Stall deasserts in the DONE cycle, and the pipeline advances on that edge.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE->MUL on accept with funct3[2]=0.
  - IDLE->DIV on accept with funct3[2]=1.
  - MUL->DONE after MUL_LAT-1 further cycles. For MUL_LAT=1, go straight IDLE->DONE.
  - DIV->DONE after XLEN iteration cycles.
  - DONE->IDLE unconditionally.
- Latency: op_done is high in DONE, exactly 1 cycle.
  - MUL: op_done is MUL_LAT cycles after the accept edge.
  - DIV: op_done is XLEN+1 cycles after the accept edge (33 for XLEN=32).
  - With DIV_EARLY=1, the special divide cases reach DONE directly: op_done 1 cycle after accept.
- Multiply: 2*XLEN-bit product of sign/zero-extended operands. MULH signed×signed, MULHSU signed×unsigned, MULHU unsigned×unsigned. MUL returns the low XLEN bits; the others return the high XLEN bits. The product is pipelined over MUL_LAT registers.
- Divide: restoring radix-2 divider on magnitudes, 1 quotient bit per cycle, MSB first. Signs are applied at DONE:
  - quotient negative iff signs differ (DIV);
  - remainder takes the dividend's sign (REM).
- Divide by zero (rs2==0): quotient = all ones; remainder = rs1.
- Signed overflow (DIV/REM, rs1 = most negative, rs2 = -1): quotient = rs1; remainder = 0.
- Flush: ip_flush=1 in any non-IDLE state returns the FSM to IDLE on the next edge with op_done=0. ip_flush=1 in IDLE blocks accept. Flush in DONE suppresses nothing, since done is already asserted that cycle.
- op_result holds its value until the next op_done.
- Inputs other than ip_flush are ignored while busy. Back-to-back M instructions are accepted in the cycle after DONE.

Decomposition:
- Shared package/macro file gets:
  - M_OPCODE (7'b0110011) and M_FUNCT7 (7'b0000001);
  - funct3 encodings MUL..REMU;
  - FSM state encoding (2 bits: IDLE=00, MUL=01, DIV=10, DONE=11).
- One natural sub-module, m_ext_div_core: iterative magnitude divider with start/done, XLEN parameter, quotient/remainder outputs. The multiplier and sign fix-up stay in the top.

Test Plan:
- MUL, rs1=7, rs2=-3 (0xFFFFFFFD), MUL_LAT=2 -> op_stall high from the accept cycle; op_done 2 cycles later; op_result=0xFFFFFFEB.
- MULHU, rs1=0xFFFFFFFF, rs2=0xFFFFFFFF -> op_result=0xFFFFFFFE. MULH with the same operands -> 0x00000000. MULHSU with the same operands -> 0xFFFFFFFF.
- DIV, rs1=-20, rs2=3 -> op_done 33 cycles after accept; result 0xFFFFFFFA (-6). REM with the same operands -> 0xFFFFFFFE (-2). DIVU, rs1=100, rs2=7 -> 14. REMU with the same operands -> 2.
- DIVU, rs1=5, rs2=0 -> op_result=0xFFFFFFFF; op_done 1 cycle after accept (DIV_EARLY=1). REM, rs1=0x80000000, rs2=0xFFFFFFFF -> 0.
- Start DIV, assert ip_flush at cycle 10 -> FSM IDLE next edge; no op_done; op_stall low. A following MUL completes normally.
- Start DIV, assert ip_rst at cycle 5 -> all outputs 0 immediately, without waiting for a clock edge. Non-M opcode (0110011, funct7=0000000) -> op_stall never asserts.
